// File: rtl/command_controller_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : command_controller_pkg                                     |
// | Description : Command/response byte codes, FSM state encoding and        |
// |               continuous-mode / read-kind types for command_controller.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package command_controller_pkg;

  // Command codes received from the PC (first byte of the 2-byte command)
  localparam logic [7:0] CMD_STATUS    = 8'h00;
  localparam logic [7:0] CMD_TEMP      = 8'h01;
  localparam logic [7:0] CMD_HUM       = 8'h02;
  localparam logic [7:0] CMD_CONT_TEMP = 8'h03;
  localparam logic [7:0] CMD_CONT_HUM  = 8'h04;
  localparam logic [7:0] CMD_STOP_TEMP = 8'h05;
  localparam logic [7:0] CMD_STOP_HUM  = 8'h06;

  // Response codes sent back (first byte of the 2-byte reply)
  localparam logic [7:0] RSP_STATUS_OK = 8'h07;
  localparam logic [7:0] RSP_HUM       = 8'h08;
  localparam logic [7:0] RSP_TEMP      = 8'h09;
  localparam logic [7:0] RSP_STOP_TEMP = 8'h0A;
  localparam logic [7:0] RSP_STOP_HUM  = 8'h0B;
  localparam logic [7:0] RSP_FAULT     = 8'h1F;
  localparam logic [7:0] RSP_BAD_CMD   = 8'hCF;
  localparam logic [7:0] RSP_BAD_ADDR  = 8'hEF;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_DECODE       = 3'd1,
    ST_GAP_WAIT     = 3'd2,
    ST_SENSOR_START = 3'd3,
    ST_SENSOR_WAIT  = 3'd4,
    ST_LOAD_TX      = 3'd5,
    ST_TX_WAIT      = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    CONT_OFF  = 2'b00,
    CONT_TEMP = 2'b01,
    CONT_HUM  = 2'b10
  } cont_mode_e;

  // Which reply a sensor measurement turns into
  typedef enum logic [1:0] {
    RD_STATUS = 2'd0,
    RD_TEMP   = 2'd1,
    RD_HUM    = 2'd2
  } read_kind_e;

endpackage : command_controller_pkg
`default_nettype wire

// File: rtl/command_controller_interval_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : interval_timer                                             |
// | Description : Loadable down-counter that saturates at zero and flags     |
// |               when it has reached zero. Load has priority over count.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module interval_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             count_en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload, or step down towards zero and stay there
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_value;
    end else if (count_en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Counter register; reset to zero so the interval starts out elapsed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule : interval_timer
`default_nettype wire

// File: rtl/command_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : command_controller                                         |
// | Description : Sequencer between the UART command path and the DHT11      |
// |               SensorDecoder: decodes 2-byte commands, paces and          |
// |               supervises sensor reads, builds 2-byte replies and runs    |
// |               the continuous temperature/humidity modes.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module command_controller
  import command_controller_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int MIN_GAP_CYC = CLK_HZ * 2,
  parameter int TIMEOUT_CYC = CLK_HZ / 10,
  parameter int NUM_SENSORS = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_byte1,
  input  logic [7:0] rx_byte2,
  output logic       sensor_enable,
  output logic       sensor_reset,
  input  logic       sensor_done,
  input  logic       sensor_error,
  input  logic [7:0] hum_int,
  input  logic [7:0] temp_int,
  output logic       tx_start,
  output logic [7:0] tx_byte1,
  output logic [7:0] tx_byte2,
  input  logic       tx_busy,
  output logic [1:0] cont_mode
);

  localparam int               MAX_CYC      = (MIN_GAP_CYC > TIMEOUT_CYC) ? MIN_GAP_CYC : TIMEOUT_CYC;
  localparam int               CNT_W        = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(MIN_GAP_CYC);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYC);
  localparam logic [8:0]       ADDR_LIMIT   = 9'(NUM_SENSORS);

  state_e     state_q,       state_d;
  cont_mode_e cont_mode_q,   cont_mode_d;
  read_kind_e read_kind_q,   read_kind_d;
  logic       pend_valid_q,  pend_valid_d;
  logic [7:0] pend_code_q,   pend_code_d;
  logic [7:0] pend_addr_q,   pend_addr_d;
  logic [7:0] cmd_code_q,    cmd_code_d;
  logic [7:0] cmd_addr_q,    cmd_addr_d;
  logic [7:0] tx_byte1_q,    tx_byte1_d;
  logic [7:0] tx_byte2_q,    tx_byte2_d;
  logic       tx_start_q,    tx_start_d;
  logic       sensor_en_q,   sensor_en_d;
  logic       sensor_rst_q,  sensor_rst_d;
  logic       busy_seen_q,   busy_seen_d;
  logic       fault;
  logic       gap_zero;
  logic       timeout_zero;
  logic       start_cycle;

  assign start_cycle = (state_q == ST_SENSOR_START);

  // Enforces DHT11 start spacing and doubles as the continuous-mode period
  interval_timer #(.WIDTH(CNT_W)) u_gap_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (start_cycle),
    .load_value (GAP_LOAD),
    .count_en   (1'b1),
    .zero       (gap_zero)
  );

  // Bounds how long a measurement may take before it is declared a fault
  interval_timer #(.WIDTH(CNT_W)) u_timeout_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (start_cycle),
    .load_value (TIMEOUT_LOAD),
    .count_en   (state_q == ST_SENSOR_WAIT),
    .zero       (timeout_zero)
  );

  // Next-state, pending-buffer and registered-output logic
  always_comb begin
    state_d      = state_q;
    cont_mode_d  = cont_mode_q;
    read_kind_d  = read_kind_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    pend_addr_d  = pend_addr_q;
    cmd_code_d   = cmd_code_q;
    cmd_addr_d   = cmd_addr_q;
    tx_byte1_d   = tx_byte1_q;
    tx_byte2_d   = tx_byte2_q;
    tx_start_d   = 1'b0;
    sensor_en_d  = sensor_en_q;
    sensor_rst_d = 1'b0;
    busy_seen_d  = busy_seen_q;
    fault        = 1'b0;

    // A command arriving while busy is parked; a newer one replaces it
    if (rx_done && (state_q != ST_IDLE)) begin
      pend_valid_d = 1'b1;
      pend_code_d  = rx_byte1;
      pend_addr_d  = rx_byte2;
    end

    case (state_q)
      ST_IDLE: begin
        busy_seen_d = 1'b0;
        if (pend_valid_q) begin
          // Oldest command first; a same-cycle arrival takes its place
          cmd_code_d   = pend_code_q;
          cmd_addr_d   = pend_addr_q;
          pend_valid_d = rx_done;
          if (rx_done) begin
            pend_code_d = rx_byte1;
            pend_addr_d = rx_byte2;
          end
          state_d = ST_DECODE;
        end else if (rx_done) begin
          cmd_code_d = rx_byte1;
          cmd_addr_d = rx_byte2;
          state_d    = ST_DECODE;
        end else if ((cont_mode_q != CONT_OFF) && gap_zero) begin
          // Continuous tick: the gap counter stays at zero until the next
          // start, so a tick deferred by a command is still seen here later
          read_kind_d = (cont_mode_q == CONT_TEMP) ? RD_TEMP : RD_HUM;
          state_d     = ST_GAP_WAIT;
        end
      end

      ST_DECODE: begin
        tx_byte1_d = RSP_BAD_CMD;
        tx_byte2_d = 8'h00;
        state_d    = ST_LOAD_TX;
        if (cmd_code_q > CMD_STOP_HUM) begin
          tx_byte1_d = RSP_BAD_CMD;
        end else if ({1'b0, cmd_addr_q} >= ADDR_LIMIT) begin
          tx_byte1_d = RSP_BAD_ADDR;
          tx_byte2_d = cmd_addr_q;
        end else begin
          case (cmd_code_q)
            CMD_STATUS: begin
              read_kind_d = RD_STATUS;
              state_d     = ST_GAP_WAIT;
            end
            CMD_TEMP: begin
              read_kind_d = RD_TEMP;
              state_d     = ST_GAP_WAIT;
            end
            CMD_HUM: begin
              read_kind_d = RD_HUM;
              state_d     = ST_GAP_WAIT;
            end
            // Mode switches are silent; the first reply comes with the tick
            CMD_CONT_TEMP: begin
              cont_mode_d = CONT_TEMP;
              state_d     = ST_IDLE;
            end
            CMD_CONT_HUM: begin
              cont_mode_d = CONT_HUM;
              state_d     = ST_IDLE;
            end
            CMD_STOP_TEMP: begin
              if (cont_mode_q == CONT_TEMP) begin
                cont_mode_d = CONT_OFF;
                tx_byte1_d  = RSP_STOP_TEMP;
              end
            end
            CMD_STOP_HUM: begin
              if (cont_mode_q == CONT_HUM) begin
                cont_mode_d = CONT_OFF;
                tx_byte1_d  = RSP_STOP_HUM;
              end
            end
            default: begin
              tx_byte1_d = RSP_BAD_CMD;
            end
          endcase
        end
      end

      ST_GAP_WAIT: begin
        if (gap_zero) begin
          sensor_rst_d = 1'b1;
          state_d      = ST_SENSOR_START;
        end
      end

      ST_SENSOR_START: begin
        sensor_en_d = 1'b1;
        state_d     = ST_SENSOR_WAIT;
      end

      ST_SENSOR_WAIT: begin
        if (sensor_done) begin
          sensor_en_d = 1'b0;
          state_d     = ST_LOAD_TX;
          tx_byte2_d  = 8'h00;
          if (sensor_error) begin
            fault = 1'b1;
          end else begin
            case (read_kind_q)
              RD_TEMP: begin
                tx_byte1_d = RSP_TEMP;
                tx_byte2_d = temp_int;
              end
              RD_HUM: begin
                tx_byte1_d = RSP_HUM;
                tx_byte2_d = hum_int;
              end
              default: begin
                tx_byte1_d = RSP_STATUS_OK;
              end
            endcase
          end
        end else if (timeout_zero) begin
          // Clear the decoder so a stuck transfer cannot leak into the next read
          sensor_en_d  = 1'b0;
          sensor_rst_d = 1'b1;
          fault        = 1'b1;
          state_d      = ST_LOAD_TX;
        end
        if (fault) begin
          tx_byte1_d  = RSP_FAULT;
          tx_byte2_d  = 8'h00;
          cont_mode_d = CONT_OFF;
        end
      end

      ST_LOAD_TX: begin
        if (!tx_busy) begin
          tx_start_d  = 1'b1;
          busy_seen_d = 1'b0;
          state_d     = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        if (tx_busy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Controller state and registered outputs; reset drops everything at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cont_mode_q  <= CONT_OFF;
      read_kind_q  <= RD_STATUS;
      pend_valid_q <= 1'b0;
      pend_code_q  <= 8'h00;
      pend_addr_q  <= 8'h00;
      cmd_code_q   <= 8'h00;
      cmd_addr_q   <= 8'h00;
      tx_byte1_q   <= 8'h00;
      tx_byte2_q   <= 8'h00;
      tx_start_q   <= 1'b0;
      sensor_en_q  <= 1'b0;
      sensor_rst_q <= 1'b0;
      busy_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cont_mode_q  <= cont_mode_d;
      read_kind_q  <= read_kind_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      pend_addr_q  <= pend_addr_d;
      cmd_code_q   <= cmd_code_d;
      cmd_addr_q   <= cmd_addr_d;
      tx_byte1_q   <= tx_byte1_d;
      tx_byte2_q   <= tx_byte2_d;
      tx_start_q   <= tx_start_d;
      sensor_en_q  <= sensor_en_d;
      sensor_rst_q <= sensor_rst_d;
      busy_seen_q  <= busy_seen_d;
    end
  end

  assign sensor_enable = sensor_en_q;
  assign sensor_reset  = sensor_rst_q;
  assign tx_start      = tx_start_q;
  assign tx_byte1      = tx_byte1_q;
  assign tx_byte2      = tx_byte2_q;
  assign cont_mode     = cont_mode_q;

endmodule : command_controller
`default_nettype wire

// File: tb/tb_command_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_command_controller                                      |
// | Description : Scoreboard bench for command_controller with small DHT11   |
// |               and uart_tx behavioural models.                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_command_controller;

  localparam int MIN_GAP = 60;
  localparam int TIMEOUT = 20;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_byte1 = 8'h00;
  logic [7:0] rx_byte2 = 8'h00;
  logic       sensor_done = 1'b0;
  logic       sensor_error = 1'b0;
  logic [7:0] hum_int = 8'h00;
  logic [7:0] temp_int = 8'h00;
  logic       tx_busy = 1'b0;
  logic       sensor_enable;
  logic       sensor_reset;
  logic       tx_start;
  logic [7:0] tx_byte1;
  logic [7:0] tx_byte2;
  logic [1:0] cont_mode;

  command_controller #(
    .CLK_HZ      (1000),
    .MIN_GAP_CYC (MIN_GAP),
    .TIMEOUT_CYC (TIMEOUT),
    .NUM_SENSORS (1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_done       (rx_done),
    .rx_byte1      (rx_byte1),
    .rx_byte2      (rx_byte2),
    .sensor_enable (sensor_enable),
    .sensor_reset  (sensor_reset),
    .sensor_done   (sensor_done),
    .sensor_error  (sensor_error),
    .hum_int       (hum_int),
    .temp_int      (temp_int),
    .tx_start      (tx_start),
    .tx_byte1      (tx_byte1),
    .tx_byte2      (tx_byte2),
    .tx_busy       (tx_busy),
    .cont_mode     (cont_mode)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_b1[$];
  logic [7:0] exp_b2[$];
  int         exp_cyc[$];
  int         rst_times[$];
  int         enable_rises = 0;

  // Sensor model knobs
  bit         sens_respond = 1'b1;
  bit         sens_err = 1'b0;
  logic [7:0] sens_temp = 8'h00;
  logic [7:0] sens_hum = 8'h00;
  int         sens_delay = 5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic expect_reply(input logic [7:0] b1, input logic [7:0] b2, input int at_cyc);
    exp_b1.push_back(b1);
    exp_b2.push_back(b2);
    exp_cyc.push_back(at_cyc);
  endtask

  task automatic send_cmd(input logic [7:0] b1, input logic [7:0] b2, output int when);
    @(posedge clock); #1;
    rx_byte1 = b1;
    rx_byte2 = b2;
    rx_done  = 1'b1;
    when     = cyc;
    @(posedge clock); #1;
    rx_done  = 1'b0;
  endtask

  // Wait for every expected reply to be seen and the transmitter to go quiet
  task automatic drain(input int budget);
    int n = 0;
    while (((exp_b1.size() != 0) || tx_busy) && (n < budget)) begin
      @(posedge clock);
      n++;
    end
    check("replies_drained", exp_b1.size(), 0);
    exp_b1.delete();
    exp_b2.delete();
    exp_cyc.delete();
    repeat (3) @(posedge clock);
  endtask

  task automatic wait_enable(input int budget);
    int n = 0;
    while (!sensor_enable && (n < budget)) begin
      @(posedge clock);
      n++;
    end
    check("sensor_enable_seen", {31'd0, sensor_enable}, 1);
  endtask

  // Scoreboard monitor and pulse recorder, sampled on the falling edge
  initial begin
    logic [7:0] b1, b2;
    int         c;
    logic       en_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (sensor_reset) rst_times.push_back(cyc);
      if (sensor_enable && !en_prev) enable_rises++;
      en_prev = sensor_enable;
      if (tx_start) begin
        checks++;
        if (exp_b1.size() == 0) begin
          errors++;
          $display("FAIL unexpected_reply: actual (%02h,%02h) required none", tx_byte1, tx_byte2);
        end else begin
          b1 = exp_b1.pop_front();
          b2 = exp_b2.pop_front();
          c  = exp_cyc.pop_front();
          if ((tx_byte1 !== b1) || (tx_byte2 !== b2)) begin
            errors++;
            $display("FAIL reply_bytes: actual (%02h,%02h) required (%02h,%02h)", tx_byte1, tx_byte2, b1, b2);
          end
          if (c >= 0) begin
            checks++;
            if (cyc != c) begin
              errors++;
              $display("FAIL reply_latency: actual cycle %0d required cycle %0d", cyc, c);
            end
          end
        end
      end
    end
  end

  // uart_tx model: busy for a few cycles after each start
  initial begin
    forever begin
      @(posedge clock); #1;
      if (tx_start) begin
        tx_busy = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        tx_busy = 1'b0;
      end
    end
  end

  // DHT11 decoder model: answers a fixed time after enable rises
  initial begin
    forever begin
      @(posedge sensor_enable);
      if (sens_respond) begin
        repeat (sens_delay) @(posedge clock);
        #1;
        if (sensor_enable) begin
          temp_int     = sens_temp;
          hum_int      = sens_hum;
          sensor_error = sens_err;
          sensor_done  = 1'b1;
          @(posedge clock); #1;
          sensor_done  = 1'b0;
          sensor_error = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int n0;
    int en0;
    int d;

    // Reset values
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_outputs", {16'd0, sensor_enable, sensor_reset, tx_start, tx_byte1, tx_byte2, cont_mode}, 0);
    reset = 1'b1;

    // Temperature read right after reset: start allowed immediately
    sens_temp = 8'h1A;
    expect_reply(8'h09, 8'h1A, -1);
    send_cmd(8'h01, 8'h00, t);
    drain(200);
    check("first_start_latency", rst_times[$] - t, 3);

    // Invalid code: reply exactly three cycles after rx_done
    send_cmd(8'h7E, 8'h00, t);
    expect_reply(8'hCF, 8'h00, t + 3);
    drain(50);

    // Bad address: no sensor activity
    en0 = enable_rises;
    expect_reply(8'hEF, 8'h05, -1);
    send_cmd(8'h02, 8'h05, t);
    drain(50);
    check("bad_addr_no_enable", enable_rises - en0, 0);

    // Status with silent sensor: timeout clears the decoder and faults
    sens_respond = 1'b0;
    n0 = rst_times.size();
    expect_reply(8'h1F, 8'h00, -1);
    send_cmd(8'h00, 8'h00, t);
    drain(MIN_GAP + TIMEOUT + 60);
    sens_respond = 1'b1;
    check("timeout_reset_pulses", rst_times.size() - n0, 2);
    d = rst_times[$] - rst_times[$-1];
    check("timeout_spacing_ok", {31'd0, (d >= TIMEOUT) && (d <= TIMEOUT + 4)}, 1);

    // Status ok and humidity
    expect_reply(8'h07, 8'h00, -1);
    send_cmd(8'h00, 8'h00, t);
    drain(200);
    sens_hum = 8'h37;
    expect_reply(8'h08, 8'h37, -1);
    send_cmd(8'h02, 8'h00, t);
    drain(200);

    // Stop while no continuous mode is active
    expect_reply(8'hCF, 8'h00, -1);
    send_cmd(8'h05, 8'h00, t);
    drain(50);
    check("cont_off_after_bad_stop", {30'd0, cont_mode}, 0);

    // Continuous temperature: two ticks, period check, then stop
    sens_temp = 8'h21;
    expect_reply(8'h09, 8'h21, -1);
    expect_reply(8'h09, 8'h21, -1);
    send_cmd(8'h03, 8'h00, t);
    drain(3 * MIN_GAP + 100);
    check("cont_mode_temp", {30'd0, cont_mode}, 32'h1);
    d = rst_times[$] - rst_times[$-1];
    check("tick_period_ok", {31'd0, (d >= MIN_GAP) && (d <= MIN_GAP + 6)}, 1);
    expect_reply(8'h0A, 8'h00, -1);
    send_cmd(8'h05, 8'h00, t);
    drain(50);
    check("cont_off_after_stop", {30'd0, cont_mode}, 0);
    repeat (2 * MIN_GAP) @(posedge clock);

    // Continuous humidity, switched to temperature without a reply, stopped
    sens_hum = 8'h45;
    expect_reply(8'h08, 8'h45, -1);
    send_cmd(8'h04, 8'h00, t);
    drain(2 * MIN_GAP + 50);
    check("cont_mode_hum", {30'd0, cont_mode}, 32'h2);
    send_cmd(8'h03, 8'h00, t);
    repeat (4) @(posedge clock);
    check("cont_mode_replaced", {30'd0, cont_mode}, 32'h1);
    expect_reply(8'h09, 8'h21, -1);
    drain(2 * MIN_GAP + 50);
    expect_reply(8'h0A, 8'h00, -1);
    send_cmd(8'h05, 8'h00, t);
    drain(50);

    // Sensor fault during continuous mode clears the mode
    sens_err = 1'b1;
    expect_reply(8'h1F, 8'h00, -1);
    send_cmd(8'h03, 8'h00, t);
    drain(2 * MIN_GAP + 50);
    sens_err = 1'b0;
    check("cont_off_after_fault", {30'd0, cont_mode}, 0);
    repeat (2 * MIN_GAP) @(posedge clock);

    // Back-to-back reads via pending buffer; newer pending command wins
    sens_delay = 12;
    sens_temp  = 8'h33;
    sens_hum   = 8'h44;
    expect_reply(8'h09, 8'h33, -1);
    expect_reply(8'h08, 8'h44, -1);
    send_cmd(8'h01, 8'h00, t);
    wait_enable(2 * MIN_GAP);
    send_cmd(8'h02, 8'h05, t);
    send_cmd(8'h02, 8'h00, t);
    drain(3 * MIN_GAP + 50);
    sens_delay = 5;
    d = rst_times[$] - rst_times[$-1];
    check("b2b_start_gap_ok", {31'd0, d >= MIN_GAP}, 1);

    // Reset asserted while waiting on the sensor
    sens_respond = 1'b0;
    send_cmd(8'h01, 8'h00, t);
    wait_enable(2 * MIN_GAP);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("reset_in_wait_outputs", {16'd0, sensor_enable, sensor_reset, tx_start, tx_byte1, tx_byte2, cont_mode}, 0);
    @(negedge clock);
    reset = 1'b1;
    sens_respond = 1'b1;

    // After reset a read may start immediately again
    sens_temp = 8'h55;
    expect_reply(8'h09, 8'h55, -1);
    send_cmd(8'h01, 8'h00, t);
    drain(200);
    check("post_reset_start_latency", rst_times[$] - t, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_command_controller
`default_nettype wire
